// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_param
//  Description : Parametrised, fully synchronous SPI master. Shifts one
//                FRAME_WIDTH-bit frame out on mosi while capturing a
//                full-width frame from miso. Supports all four CPOL/CPHA
//                modes, MSB- or LSB-first bit order, a programmable SCLK
//                half-period divider and chip-select setup/hold guard times.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FRAME_WIDTH  bits per transfer (>= 2)
//    HALF_DIV     sysclk cycles per SCLK half-period (>= 1)
//    CPOL         SCLK idle level
//    CPHA         0: sample on leading edge, shift on trailing edge
//                 1: shift on leading edge, sample on trailing edge
//    MSB_FIRST    1: MSB shifted first, 0: LSB first (tx and rx)
//    CS_SETUP     cycles of cs low before the first SCLK interval (>= 1)
//    CS_HOLD      cycles of cs low after the last SCLK edge (>= 1)
//  Ports
//    sysclk   in   system clock, all logic on the rising edge
//    rst_n    in   synchronous reset, active low
//    tx_enb   in   start request, accepted only while tx_ready is high
//    i_frame  in   transmit frame, sampled on accept
//    tx_ready out  high in IDLE
//    miso     in   serial data from the slave
//    cs       out  chip select, active low
//    sclk     out  SPI clock, driven straight from a flop
//    mosi     out  serial data to the slave
//    o_frame  out  last received frame, natural bit order
//    o_valid  out  one-cycle pulse when o_frame is updated
// ============================================================================
module spi_master_param #(
  parameter int FRAME_WIDTH = 32,
  parameter int HALF_DIV    = 3,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   tx_enb,
  input  logic [FRAME_WIDTH-1:0] i_frame,
  output logic                   tx_ready,
  input  logic                   miso,
  output logic                   cs,
  output logic                   sclk,
  output logic                   mosi,
  output logic [FRAME_WIDTH-1:0] o_frame,
  output logic                   o_valid
);

  // --------------------------------------------------------------------------
  // Derived sizes and terminal counts
  // --------------------------------------------------------------------------
  localparam int EDGES     = 2 * FRAME_WIDTH;
  localparam int DIV_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int EDGE_W    = $clog2(EDGES);
  localparam int GUARD_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GUARD_W   = (GUARD_MAX > 1) ? $clog2(GUARD_MAX) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(HALF_DIV - 1);
  localparam logic [EDGE_W-1:0]  EDGE_LAST  = EDGE_W'(EDGES - 1);
  localparam logic [GUARD_W-1:0] SETUP_LAST = GUARD_W'(CS_SETUP - 1);
  localparam logic [GUARD_W-1:0] HOLD_LAST  = GUARD_W'(CS_HOLD - 1);
  localparam logic               SCLK_IDLE  = (CPOL != 0);
  localparam logic               TX_ON_LEAD = (CPHA != 0);
  localparam logic               MSB_ORDER  = (MSB_FIRST != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Bit-order helpers: the tx register always keeps the next bit to send at
  // its "front" end, and the rx register fills so that after FRAME_WIDTH
  // captures the word sits in natural bit order.
  // --------------------------------------------------------------------------
  function automatic logic front_bit(input logic [FRAME_WIDTH-1:0] v);
    return MSB_ORDER ? v[FRAME_WIDTH-1] : v[0];
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] drop_front(input logic [FRAME_WIDTH-1:0] v);
    return MSB_ORDER ? {v[FRAME_WIDTH-2:0], 1'b0} : {1'b0, v[FRAME_WIDTH-1:1]};
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] push_bit(input logic [FRAME_WIDTH-1:0] v,
                                                      input logic b);
    return MSB_ORDER ? {v[FRAME_WIDTH-2:0], b} : {b, v[FRAME_WIDTH-1:1]};
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [GUARD_W-1:0]     guard_q, guard_d;
  logic [DIV_W-1:0]       div_q,   div_d;
  logic [EDGE_W-1:0]      edge_q,  edge_d;
  logic [FRAME_WIDTH-1:0] tx_q,    tx_d;
  logic [FRAME_WIDTH-1:0] rx_q,    rx_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   cs_q,    cs_d;
  logic                   sclk_q,  sclk_d;
  logic                   mosi_q,  mosi_d;
  logic                   valid_q, valid_d;

  // An sclk toggle happens at the end of every HALF_DIV-cycle interval.
  // edge_q counts edges already emitted, so an even count means the edge
  // about to be emitted is a leading one.
  logic tick;
  logic lead_edge;
  logic last_edge;

  assign tick      = (state_q == ST_SHIFT) && (div_q == DIV_LAST);
  assign lead_edge = ~edge_q[0];
  assign last_edge = (edge_q == EDGE_LAST);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      guard_q <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      frame_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= SCLK_IDLE;
      mosi_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      frame_q <= frame_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic. Every pin is a flop, so the
  // values computed here are the pin levels for the cycle after this edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    frame_d = frame_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = SCLK_IDLE;
        mosi_d = 1'b0;
        if (tx_enb) begin
          state_d = ST_SETUP;
          guard_d = '0;
          div_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          cs_d    = 1'b0;
          if (TX_ON_LEAD) begin
            // First bit goes out on leading edge 1.
            tx_d   = i_frame;
            mosi_d = 1'b0;
          end else begin
            // First bit is already on the wire during the whole setup time.
            tx_d   = drop_front(i_frame);
            mosi_d = front_bit(i_frame);
          end
        end
      end

      ST_SETUP: begin
        if (guard_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (lead_edge) begin
            if (TX_ON_LEAD) begin
              mosi_d = front_bit(tx_q);
              tx_d   = drop_front(tx_q);
            end else begin
              rx_d = push_bit(rx_q, miso);
            end
          end else begin
            if (TX_ON_LEAD) begin
              rx_d = push_bit(rx_q, miso);
            end else if (!last_edge) begin
              // No new bit after the final trailing edge: mosi holds
              // the last bit through HOLD.
              mosi_d = front_bit(tx_q);
              tx_d   = drop_front(tx_q);
            end
          end
          if (last_edge) begin
            state_d = ST_HOLD;
            edge_d  = '0;
            guard_d = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (guard_q == HOLD_LAST) begin
          state_d = ST_DONE;
          guard_d = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          frame_d = rx_q;
          valid_d = 1'b1;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sclk_d  = SCLK_IDLE;
        mosi_d  = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign o_frame  = frame_q;
  assign o_valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_param
//  Description : Self-checking bench for spi_master_param. Three instances
//                cover mode 0 MSB-first, mode 3 MSB-first and mode 2
//                LSB-first. Each has a behavioural SPI slave that returns a
//                chosen word and records what it received on mosi.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int SU  = 2;
  localparam int HO  = 2;
  localparam int NI  = 3;
  // Cycle index of the o_valid cycle, numbering the accept cycle as 0.
  localparam int LAT = SU + 2 * W * H + HO + 1;
  localparam logic [NI-1:0] P_CPOL = 3'b110;
  localparam logic [NI-1:0] P_CPHA = 3'b010;
  localparam logic [NI-1:0] P_MSB  = 3'b011;

  logic clk;
  logic rst_n    [NI];
  logic tx_enb   [NI];
  logic tx_ready [NI];
  logic miso     [NI];
  logic cs       [NI];
  logic sclk     [NI];
  logic mosi     [NI];
  logic o_valid  [NI];
  logic loop_en  [NI];
  logic slv_bit  [NI];
  logic [W-1:0] i_frame  [NI];
  logic [W-1:0] o_frame  [NI];
  logic [W-1:0] slv_word [NI];
  logic [W-1:0] slv_rx   [NI];
  int edges  [NI];
  int ov_cnt [NI];
  int glitch [NI];

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit the slave presents after l leading and t trailing edges.
  function automatic logic slave_bit(input logic [W-1:0] word, input logic msb,
                                     input logic cpha, input int l, input int t);
    int idx;
    idx = cpha ? ((l > 0) ? l - 1 : 0) : t;
    if (idx >= W) return 1'b0;
    return msb ? word[W-1-idx] : word[idx];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam logic SCPOL = P_CPOL[g];
    localparam logic SCPHA = P_CPHA[g];
    localparam logic SMSB  = P_MSB[g];
    localparam logic SHIFT_LVL = SCPHA ? ~SCPOL : SCPOL;

    spi_master_param #(
      .FRAME_WIDTH(W), .HALF_DIV(H), .CPOL(int'(SCPOL)), .CPHA(int'(SCPHA)),
      .MSB_FIRST(int'(SMSB)), .CS_SETUP(SU), .CS_HOLD(HO)
    ) u_dut (
      .sysclk(clk), .rst_n(rst_n[g]), .tx_enb(tx_enb[g]), .i_frame(i_frame[g]),
      .tx_ready(tx_ready[g]), .miso(miso[g]), .cs(cs[g]), .sclk(sclk[g]),
      .mosi(mosi[g]), .o_frame(o_frame[g]), .o_valid(o_valid[g])
    );

    assign miso[g] = loop_en[g] ? mosi[g] : slv_bit[g];

    // Behavioural slave: shifts on its shift edge, samples mosi on its
    // sample edge, counts all sclk edges while selected.
    initial begin : slave
      int l, t, j;
      logic ps, pc;
      l = 0; t = 0; ps = SCPOL; pc = 1'b1;
      slv_bit[g] = 1'b0; edges[g] = 0; slv_rx[g] = '0;
      forever begin
        @(sclk[g] or cs[g]);
        if (cs[g] === 1'b0) begin
          if (pc !== 1'b0) begin
            l = 0; t = 0; edges[g] = 0; slv_rx[g] = '0;
          end else if (sclk[g] !== ps) begin
            edges[g]++;
            if (sclk[g] !== SCPOL) begin
              l++;
              j = l - 1;
              if (!SCPHA && j < W) slv_rx[g][SMSB ? W-1-j : j] = mosi[g];
            end else begin
              t++;
              j = t - 1;
              if (SCPHA && j < W) slv_rx[g][SMSB ? W-1-j : j] = mosi[g];
            end
          end
        end
        slv_bit[g] = slave_bit(slv_word[g], SMSB, SCPHA, l, t);
        ps = sclk[g];
        pc = cs[g];
      end
    end

    // o_valid pulse counter and mosi-changes-only-on-shift-edge monitor.
    initial begin : mon
      logic pc, pm, ps;
      pc = 1'b1; pm = 1'b0; ps = SCPOL;
      ov_cnt[g] = 0; glitch[g] = 0;
      forever begin
        @(negedge clk);
        if (o_valid[g] === 1'b1) ov_cnt[g]++;
        if (pc === 1'b0 && cs[g] === 1'b0 && mosi[g] !== pm &&
            !(sclk[g] !== ps && sclk[g] === SHIFT_LVL)) glitch[g]++;
        pc = cs[g]; pm = mosi[g]; ps = sclk[g];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // --------------------------------------------------------------------------
  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One transfer; lat is the cycle index of o_valid (accept cycle = 0),
  // -1 on timeout.
  task automatic xfer(input int k, input logic [W-1:0] frame, input logic [W-1:0] sw,
                      input logic lp, output int lat, output logic [W-1:0] got,
                      output logic [W-1:0] sent, output int nedge, output logic ov_next);
    bit ok;
    lat = -1; got = 'x; sent = 'x; nedge = -1; ov_next = 1'bx;
    i_frame[k] = frame; slv_word[k] = sw; loop_en[k] = lp;
    wait_ready(k, ok);
    if (!ok) return;
    tx_enb[k] = 1'b1;
    @(posedge clk);
    #1 tx_enb[k] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (o_valid[k] === 1'b1) begin
        lat = c;
        break;
      end
    end
    got = o_frame[k]; sent = slv_rx[k]; nedge = edges[k];
    @(negedge clk);
    ov_next = o_valid[k];
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++; if (cs[k] !== 1'b1) begin bad++; $display("FAIL reset_cs[%0d]: got %b want 1", k, cs[k]); end
      total++; if (sclk[k] !== P_CPOL[k]) begin bad++; $display("FAIL reset_sclk[%0d]: got %b want %b", k, sclk[k], P_CPOL[k]); end
      total++; if (mosi[k] !== 1'b0) begin bad++; $display("FAIL reset_mosi[%0d]: got %b want 0", k, mosi[k]); end
      total++; if (o_frame[k] !== '0) begin bad++; $display("FAIL reset_oframe[%0d]: got %h want 00", k, o_frame[k]); end
      total++; if (o_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_ovalid[%0d]: got %b want 0", k, o_valid[k]); end
      total++; if (tx_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", k, tx_ready[k]); end
      rst_n[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++; if (sclk[k] !== P_CPOL[k] || mosi[k] !== 1'b0 || cs[k] !== 1'b1) begin
        bad++; $display("FAIL idle_pins[%0d]: got cs=%b sclk=%b mosi=%b want cs=1 sclk=%b mosi=0", k, cs[k], sclk[k], mosi[k], P_CPOL[k]);
      end
    end
  endtask

  task automatic test_mode0_loopback();
    int lat, ne; logic [W-1:0] got, sent; logic ovn; int g0;
    g0 = glitch[0];
    xfer(0, 8'hA5, 8'h00, 1'b1, lat, got, sent, ne, ovn);
    total++; if (lat !== LAT) begin bad++; $display("FAIL m0_latency: got %0d want %0d", lat, LAT); end
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL m0_oframe: got %h want a5", got); end
    total++; if (sent !== 8'hA5) begin bad++; $display("FAIL m0_mosi_bits: got %h want a5", sent); end
    total++; if (ne !== 2 * W) begin bad++; $display("FAIL m0_edges: got %0d want %0d", ne, 2 * W); end
    total++; if (ovn !== 1'b0) begin bad++; $display("FAIL m0_ovalid_width: got %b want 0", ovn); end
    total++; if (glitch[0] !== g0) begin bad++; $display("FAIL m0_mosi_timing: got %0d want %0d", glitch[0], g0); end
  endtask

  task automatic test_mode3();
    int lat, ne; logic [W-1:0] got, sent, f; logic ovn; int g1;
    f = W'($urandom); g1 = glitch[1];
    total++; if (sclk[1] !== 1'b1) begin bad++; $display("FAIL m3_idle_sclk: got %b want 1", sclk[1]); end
    xfer(1, f, 8'h3C, 1'b0, lat, got, sent, ne, ovn);
    total++; if (got !== 8'h3C) begin bad++; $display("FAIL m3_oframe: got %h want 3c", got); end
    total++; if (sent !== f) begin bad++; $display("FAIL m3_mosi: got %h want %h", sent, f); end
    total++; if (ne !== 2 * W) begin bad++; $display("FAIL m3_edges: got %0d want %0d", ne, 2 * W); end
    total++; if (glitch[1] !== g1) begin bad++; $display("FAIL m3_mosi_on_lead: got %0d want %0d", glitch[1], g1); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL m3_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_lsb_first();
    int lat, ne; logic [W-1:0] got, sent; logic ovn;
    xfer(2, 8'h01, 8'h80, 1'b0, lat, got, sent, ne, ovn);
    total++; if (got !== 8'h80) begin bad++; $display("FAIL lsb_oframe: got %h want 80", got); end
    total++; if (sent !== 8'h01) begin bad++; $display("FAIL lsb_mosi_seq: got %h want 01", sent); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL lsb_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    bit ok, dropped, saw_low; int nv, hi, gap, ov0; logic [W-1:0] vals [2];
    nv = 0; hi = 0; gap = -1; dropped = 1'b0; saw_low = 1'b0;
    vals[0] = 'x; vals[1] = 'x; ov0 = ov_cnt[0];
    loop_en[0] = 1'b1; i_frame[0] = 8'h11;
    wait_ready(0, ok);
    tx_enb[0] = 1'b1;
    @(posedge clk);
    #1 i_frame[0] = 8'h22;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (o_valid[0] === 1'b1 && nv < 2) begin vals[nv] = o_frame[0]; nv++; end
      if (cs[0] === 1'b1) hi++;
      else begin
        if (saw_low && hi > 0 && gap < 0) gap = hi;
        hi = 0; saw_low = 1'b1;
      end
      if (!dropped && nv == 1 && tx_ready[0] === 1'b1) begin
        dropped = 1'b1;
        @(posedge clk);
        #1 tx_enb[0] = 1'b0;
      end
    end
    tx_enb[0] = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (ov_cnt[0] - ov0 !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", ov_cnt[0] - ov0); end
    total++; if (gap !== 2) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 2", gap); end
    total++; if (vals[0] !== 8'h11) begin bad++; $display("FAIL b2b_frame1: got %h want 11", vals[0]); end
    total++; if (vals[1] !== 8'h22) begin bad++; $display("FAIL b2b_frame2: got %h want 22", vals[1]); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit; int ov0, sclk_bad, lat, ne; logic [W-1:0] f, got, sent; logic ovn;
    f = W'($urandom); hit = 1'b0; sclk_bad = 0;
    loop_en[0] = 1'b1; i_frame[0] = f;
    wait_ready(0, ok);
    tx_enb[0] = 1'b1;
    @(posedge clk);
    #1 tx_enb[0] = 1'b0;
    ov0 = ov_cnt[0];
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cs[0] === 1'b0 && edges[0] >= 5) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_mid_reach_edge5: got timeout want edge 5"); end
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    total++; if (cs[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_cs: got %b want 1", cs[0]); end
    total++; if (sclk[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk: got %b want 0", sclk[0]); end
    total++; if (mosi[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_mosi: got %b want 0", mosi[0]); end
    total++; if (o_frame[0] !== '0) begin bad++; $display("FAIL rst_mid_oframe: got %h want 00", o_frame[0]); end
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sclk[0] !== 1'b0 || cs[0] !== 1'b1) sclk_bad++;
    end
    total++; if (ov_cnt[0] !== ov0) begin bad++; $display("FAIL rst_mid_no_valid: got %0d want %0d", ov_cnt[0], ov0); end
    total++; if (sclk_bad !== 0) begin bad++; $display("FAIL rst_mid_quiet_pins: got %0d want 0", sclk_bad); end
    total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", tx_ready[0]); end
    f = W'($urandom);
    xfer(0, f, 8'h00, 1'b1, lat, got, sent, ne, ovn);
    total++; if (got !== f || sent !== f || lat !== LAT) begin
      bad++; $display("FAIL rst_mid_next_frame: got o=%h s=%h lat=%0d want %h %h %0d", got, sent, lat, f, f, LAT);
    end
  endtask

  task automatic test_enb_ignored();
    bit ok; int ov0, lat; logic [W-1:0] got, sent;
    loop_en[0] = 1'b1; i_frame[0] = 8'h0F; lat = -1;
    wait_ready(0, ok);
    tx_enb[0] = 1'b1;
    @(posedge clk);
    #1 tx_enb[0] = 1'b0;
    ov0 = ov_cnt[0];
    repeat (10) @(negedge clk);
    total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL ign_ready_busy: got %b want 0", tx_ready[0]); end
    i_frame[0] = 8'hFF; tx_enb[0] = 1'b1;
    @(negedge clk);
    tx_enb[0] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid[0] === 1'b1) begin lat = c; break; end
    end
    got = o_frame[0]; sent = slv_rx[0];
    repeat (60) @(negedge clk);
    total++; if (lat < 0) begin bad++; $display("FAIL ign_valid_seen: got timeout want pulse"); end
    total++; if (got !== 8'h0F) begin bad++; $display("FAIL ign_oframe: got %h want 0f", got); end
    total++; if (sent !== 8'h0F) begin bad++; $display("FAIL ign_mosi: got %h want 0f", sent); end
    total++; if (ov_cnt[0] - ov0 !== 1) begin bad++; $display("FAIL ign_transfers: got %0d want 1", ov_cnt[0] - ov0); end
  endtask

  task automatic test_random();
    int k, lat, ne; logic [W-1:0] f, sw, got, sent; logic ovn;
    for (int n = 0; n < 12; n++) begin
      k = int'($urandom_range(NI - 1, 0));
      f = W'($urandom); sw = W'($urandom);
      xfer(k, f, sw, 1'b0, lat, got, sent, ne, ovn);
      total++; if (got !== sw) begin bad++; $display("FAIL rnd_oframe[%0d] inst%0d: got %h want %h", n, k, got, sw); end
      total++; if (sent !== f) begin bad++; $display("FAIL rnd_mosi[%0d] inst%0d: got %h want %h", n, k, sent, f); end
      total++; if (lat !== LAT || ne !== 2 * W) begin
        bad++; $display("FAIL rnd_timing[%0d] inst%0d: got lat=%0d edges=%0d want %0d %0d", n, k, lat, ne, LAT, 2 * W);
      end
    end
    for (int i = 0; i < NI; i++) begin
      total++; if (glitch[i] !== 0) begin bad++; $display("FAIL mosi_shift_edge_only[%0d]: got %0d want 0", i, glitch[i]); end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; tx_enb[k] = 1'b0; i_frame[k] = '0;
      loop_en[k] = 1'b0; slv_word[k] = '0;
    end
    test_reset();
    test_mode0_loopback();
    test_mode3();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid();
    test_enb_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
